// File: rtl/qspi_xip_rd_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// qspi_xip_rd_arbiter
//
// Purpose
//   Shares one QSPI XIP flash read engine between NREQ word-read requesters
//   (for example I-fetch and D-port). Arbitration is round-robin, and only one
//   flash transaction is outstanding at a time. The engine is driven through a
//   start/done pulse handshake, and the returned word goes back to the
//   requester that was granted.
//
// Ports
//   HCLK      in   1            clock; all logic on the rising edge
//   HRESETn   in   1            synchronous, active-low reset
//   rd_req    in   NREQ         per-requester read request (level)
//   rd_addr   in   NREQ*ADDR_W  per-requester byte address, slice i = [i*ADDR_W +: ADDR_W]
//   rd_gnt    out  NREQ         one-cycle grant pulse (one-hot)
//   rd_valid  out  NREQ         one-cycle data-valid pulse (one-hot)
//   rd_err    out  1            qualifies rd_valid: transaction aborted
//   rd_data   out  32           returned word, held until the next rd_valid
//   fr_start  out  1            one-cycle start pulse to the flash read engine
//   fr_addr   out  ADDR_W       word-aligned address, held from fr_start to completion
//   fr_done   in   1            one-cycle completion pulse from the engine
//   fr_data   in   32           engine read data, valid with fr_done
//   fr_abort  out  1            one-cycle abort pulse to the engine
//
// Configuration
//   QSPI_ARB_TIMEOUT_EN : when defined, a WAIT that lasts TIMEOUT cycles without
//   fr_done is aborted (fr_abort, rd_valid with rd_err=1 and rd_data=0).
//   When undefined, WAIT lasts until fr_done, and fr_abort/rd_err stay 0.
// -----------------------------------------------------------------------------
module qspi_xip_rd_arbiter #(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = 24,
  parameter int TIMEOUT = 1024
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic [NREQ-1:0]          rd_req,
  input  logic [NREQ*ADDR_W-1:0]   rd_addr,
  output logic [NREQ-1:0]          rd_gnt,
  output logic [NREQ-1:0]          rd_valid,
  output logic                     rd_err,
  output logic [31:0]              rd_data,
  output logic                     fr_start,
  output logic [ADDR_W-1:0]        fr_addr,
  input  logic                     fr_done,
  input  logic [31:0]              fr_data,
  output logic                     fr_abort
);

  localparam int SEL_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [SEL_W-1:0]  r_sel;
  logic [SEL_W-1:0]  r_rr_ptr;
  logic [SEL_W-1:0]  w_pick;
  logic              w_pick_vld;
  logic              w_expired;

  logic [ADDR_W-3:0] w_addr_hi [NREQ];
  logic [2*NREQ-1:0] w_addr_lo;
  logic              w_unused;

  logic [NREQ-1:0]   r_gnt;
  logic [NREQ-1:0]   r_valid;
  logic              r_err;
  logic              r_start;
  logic              r_abort;
  logic [31:0]       r_data;
  logic [ADDR_W-1:0] r_addr;

  function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] s);
    logic [NREQ-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

  // Split each requester address into the word part that goes to the engine
  // and the byte-offset bits, which are discarded.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign w_addr_hi[gi]        = rd_addr[gi*ADDR_W+2 +: ADDR_W-2];
      assign w_addr_lo[2*gi +: 2] = rd_addr[gi*ADDR_W +: 2];
    end
  endgenerate

  assign w_unused = ^w_addr_lo;

  // Round-robin pick: the first asserted request after r_rr_ptr, circularly.
  // The scan runs from the farthest offset to the nearest one, so the nearest
  // asserted requester is the last to overwrite w_pick and therefore wins.
  always_comb begin
    w_pick     = r_rr_ptr;
    w_pick_vld = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      if (rd_req[(int'(r_rr_ptr) + k) % NREQ]) begin
        w_pick     = SEL_W'((int'(r_rr_ptr) + k) % NREQ);
        w_pick_vld = 1'b1;
      end
    end
  end

`ifdef QSPI_ARB_TIMEOUT_EN
  logic [15:0] r_wait_cnt;

  // The counter is zero in the fr_start cycle and advances on every WAIT
  // cycle. Expiry is therefore seen TIMEOUT-1 cycles after fr_start, and the
  // abort becomes visible TIMEOUT cycles after fr_start.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_wait_cnt <= '0;
    end else if (r_state == ST_IDLE && w_pick_vld) begin
      r_wait_cnt <= '0;
    end else if (r_state == ST_WAIT) begin
      r_wait_cnt <= r_wait_cnt + 16'd1;
    end
  end

  assign w_expired = (r_state == ST_WAIT) && (r_wait_cnt == 16'(TIMEOUT - 1));
`else
  assign w_expired = 1'b0;
`endif

  // State register
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic. fr_done takes priority over timeout expiry in WAIT.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_pick_vld) w_state_next = ST_WAIT;
      ST_WAIT: if (fr_done || w_expired) w_state_next = ST_RESP;
      ST_RESP: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Registered outputs. Pulses default low every cycle, and the held values
  // (rd_data, fr_addr) change only on the corresponding event.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_gnt    <= '0;
      r_valid  <= '0;
      r_err    <= 1'b0;
      r_start  <= 1'b0;
      r_abort  <= 1'b0;
      r_data   <= '0;
      r_addr   <= '0;
      r_sel    <= '0;
      r_rr_ptr <= SEL_W'(NREQ - 1);
    end else begin
      r_gnt   <= '0;
      r_valid <= '0;
      r_err   <= 1'b0;
      r_start <= 1'b0;
      r_abort <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pick_vld) begin
            r_gnt    <= onehot(w_pick);
            r_start  <= 1'b1;
            r_addr   <= {w_addr_hi[w_pick], 2'b00};
            r_sel    <= w_pick;
            r_rr_ptr <= w_pick;
          end
        end
        ST_WAIT: begin
          if (fr_done) begin
            r_valid <= onehot(r_sel);
            r_data  <= fr_data;
          end else if (w_expired) begin
            r_valid <= onehot(r_sel);
            r_err   <= 1'b1;
            r_abort <= 1'b1;
            r_data  <= 32'h0;
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_gnt   = r_gnt;
  assign rd_valid = r_valid;
  assign rd_err   = r_err;
  assign rd_data  = r_data;
  assign fr_start = r_start;
  assign fr_addr  = r_addr;
  assign fr_abort = r_abort;

endmodule
